// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner: scan states,
// active-low segment patterns for hex digits and the all-off codes.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } scan_state_e;

    // Segment patterns are {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [3:0] anode_mask(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Nibble to segment pattern lookup.
    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'h0:    seg_n = SEG_HEX_0;
            4'h1:    seg_n = SEG_HEX_1;
            4'h2:    seg_n = SEG_HEX_2;
            4'h3:    seg_n = SEG_HEX_3;
            4'h4:    seg_n = SEG_HEX_4;
            4'h5:    seg_n = SEG_HEX_5;
            4'h6:    seg_n = SEG_HEX_6;
            4'h7:    seg_n = SEG_HEX_7;
            4'h8:    seg_n = SEG_HEX_8;
            4'h9:    seg_n = SEG_HEX_9;
            4'hA:    seg_n = SEG_HEX_A;
            4'hB:    seg_n = SEG_HEX_B;
            4'hC:    seg_n = SEG_HEX_C;
            4'hD:    seg_n = SEG_HEX_D;
            4'hE:    seg_n = SEG_HEX_E;
            4'hF:    seg_n = SEG_HEX_F;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with dead time between digits.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        scan_tick_in,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_in,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n
);

    localparam logic [3:0] DEAD_LAST = 4'(DEAD_CYCLES - 1);

    logic        sync1_r, sync2_r, prev_r, step_r;
    logic [15:0] disp_r, disp_next_s;
    scan_state_e state_r, state_next_s;
    logic [1:0]  idx_r, idx_next_s;
    logic [3:0]  dead_cnt_r, cnt_next_s;
    logic [3:0]  nibble_s;
    logic [6:0]  dec_seg_s;
    logic        lz_blank_s;

    // Synchronize the divider output and turn its rising edge into a step pulse.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            step_r  <= 1'b0;
        end else begin
            sync1_r <= scan_tick_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            step_r  <= sync2_r & ~prev_r;
        end
    end

    // A load on this edge is visible to the digit being entered on this edge.
    always_comb begin
        disp_next_s = disp_r;
        if (load) begin
            disp_next_s = value_in;
        end else begin
            disp_next_s = disp_r;
        end
    end

    // Scan state transitions; blank_in overrides everything, steps in DEAD are dropped.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = dead_cnt_r;
        if (blank_in) begin
            state_next_s = BLANK;
            idx_next_s   = 2'd0;
            cnt_next_s   = 4'd0;
        end else begin
            case (state_r)
                BLANK: begin
                    if (step_r) begin
                        state_next_s = DRIVE;
                        idx_next_s   = 2'd0;
                    end else begin
                        state_next_s = BLANK;
                    end
                end
                DRIVE: begin
                    if (step_r) begin
                        state_next_s = DEAD;
                        idx_next_s   = idx_r + 2'd1;
                        cnt_next_s   = 4'd0;
                    end else begin
                        state_next_s = DRIVE;
                    end
                end
                DEAD: begin
                    if (dead_cnt_r == DEAD_LAST) begin
                        state_next_s = DRIVE;
                        cnt_next_s   = 4'd0;
                    end else begin
                        cnt_next_s   = dead_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_next_s = BLANK;
                    idx_next_s   = 2'd0;
                    cnt_next_s   = 4'd0;
                end
            endcase
        end
    end

    assign nibble_s = disp_next_s[{idx_next_s, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_s),
        .seg_n  (dec_seg_s)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_blank_s = 1'b0;
        case (idx_next_s)
            2'd3:    lz_blank_s = (disp_next_s[15:12] == 4'h0);
            2'd2:    lz_blank_s = (disp_next_s[15:8] == 8'h00);
            2'd1:    lz_blank_s = (disp_next_s[15:4] == 12'h000);
            default: lz_blank_s = 1'b0;
        endcase
    end
`else
    assign lz_blank_s = 1'b0;
`endif

    // State, display register and registered anode/segment outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= BLANK;
            idx_r      <= 2'd0;
            dead_cnt_r <= 4'd0;
            disp_r     <= 16'h0000;
            an_n       <= AN_OFF;
            seg_n      <= SEG_OFF;
        end else begin
            state_r    <= state_next_s;
            idx_r      <= idx_next_s;
            dead_cnt_r <= cnt_next_s;
            disp_r     <= disp_next_s;
            if (state_next_s == DRIVE) begin
                an_n  <= anode_mask(idx_next_s);
                seg_n <= lz_blank_s ? SEG_OFF : dec_seg_s;
            end else begin
                an_n  <= AN_OFF;
                seg_n <= SEG_OFF;
            end
        end
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 2, meaning the number of clock_in cycles all anodes stay off between digits (legal range 1..15).
REQ-002 SHALL have port clock_in, input, 1 bit: the single system clock, the same undivided clock that feeds the clock divider.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port scan_tick_in, input, 1 bit: clock_out of the clock divider, used as data, never as a clock.
REQ-005 SHALL have port value_in, input, 16 bits: four hex digits to display; digit 0 is bits [3:0].
REQ-006 SHALL have port load, input, 1 bit: a one-cycle strobe that captures value_in.
REQ-007 SHALL have port blank_in, input, 1 bit: a level that forces the display dark while high.
REQ-008 SHALL have port seg_n, output, 7 bits: active-low segments; bit 0 is a and bit 6 is g.
REQ-009 SHALL have port an_n, output, 4 bits: active-low anodes; an_n[k] drives digit k.

Function
REQ-010 SHALL pass scan_tick_in through a 2-FF synchronizer, then a rising-edge detector, producing a one-cycle step pulse 3 clock_in cycles after the scan_tick_in rise.
REQ-011 SHALL capture value_in into a 16-bit display register on the clock edge where load=1; a capture never disturbs the scan state.
REQ-012 SHALL implement three states:
- BLANK: all anodes off.
- DRIVE: one anode on.
- DEAD: all anodes off.
REQ-013 BLANK->DRIVE SHALL occur on step when blank_in=0, with digit index 0.
REQ-014 DRIVE->DEAD SHALL occur on step: anodes off in the same cycle, and the digit index increments modulo 4 (3 wraps to 0).
REQ-015 DEAD->DRIVE SHALL occur after exactly DEAD_CYCLES cycles in DEAD; a step arriving during DEAD is dropped.
REQ-016 In any state, blank_in=1 SHALL force BLANK on the next edge, with digit index 0, an_n=4'hF and seg_n=7'h7F; blank_in takes priority over a simultaneous step.
REQ-017 In DRIVE, seg_n SHALL hold the decode of the indexed nibble, and an_n SHALL be all ones except bit index=0.
REQ-018 seg_n and an_n SHALL be registered and change on the same edge.
REQ-019 SHALL decode nibbles as follows (seg_n, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 When load and the DEAD->DRIVE transition coincide, the newly entered digit SHALL show the newly loaded value.

Reset
REQ-021 SHALL apply the following while reset_n=0, asynchronously:
- state=BLANK, digit index=0
- display register=16'h0000
- synchronizer and edge flops=0
- an_n=4'hF, seg_n=7'h7F
REQ-022 A reset asserted mid-scan SHALL turn the outputs off immediately.
REQ-023 After reset release, the first step with blank_in=0 SHALL start scanning at digit 0.

Configuration
REQ-024 With macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, zero digits above the most significant non-zero digit SHALL display blank.
- Blank means seg_n=7'h7F with the anode still driven.
- Digit 0 is always shown.
REQ-025 Without SEVEN_SEG_LEADING_ZERO_BLANK_EN, all four digits SHALL always display their decoded value.

Structure
REQ-026 Package seven_seg_pkg SHALL hold:
- the state enum (BLANK, DRIVE, DEAD);
- the 16-entry segment pattern constants;
- the SEG_OFF=7'h7F and AN_OFF=4'hF constants.
REQ-027 A combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) SHALL implement REQ-019, instantiated once.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Scan: load 16'h1234, blank_in=0, 4 ticks. The bench sees an_n 1110/1101/1011/0111 with seg_n 0011001, 0110000, 0100100, 1111001 (digits 4, 3, 2, 1), each preceded by 2 cycles of an_n=1111.
- Wrap: 5 ticks after load 16'hABCD. The fifth DRIVE is digit 0 again, showing seg_n=0100001 (d).
- Blank override: assert blank_in mid-DRIVE, coincident with a step. Next edge: an_n=1111, seg_n=7F. Deassert; the next tick resumes at digit 0.
- Reset mid-scan: pull reset_n low mid-cycle. an_n=1111 with no clock edge; after release, nothing happens until a tick.
- Leading-zero blanking, load 16'h0050:
  - with SEVEN_SEG_LEADING_ZERO_BLANK_EN, digit 3 shows 7F, digit 2 shows 7F, digit 1 shows 0010010, digit 0 shows 1000000;
  - without SEVEN_SEG_LEADING_ZERO_BLANK_EN, digits 3 and 2 show 1000000.
- Step during DEAD: a second tick edge inside the DEAD window is ignored, and the digit advances by exactly 1.
